// File: rtl/height_digit_render.sv
// Height readout: saturating binary-to-BCD converter plus a 3-digit glyph window renderer.
// Optional `LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module height_digit_render #(
  parameter logic [9:0] X0       = 10'd272,
  parameter logic [9:0] Y0       = 10'd224,
  parameter logic [5:0] BG_COLOR = 6'b111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] height_in,
  input  logic       height_valid,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  output logic [4:0] glyph_col,
  output logic [4:0] glyph_row,
  output logic [3:0] glyph_digit,
  input  logic [5:0] glyph_data,
  output logic [5:0] rgb,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t      state, state_next;
  logic        req_full;
  logic [9:0]  req_val;
  logic [9:0]  height_sat;
  logic [21:0] dd;
  logic [3:0]  step;
  logic [11:0] pending;
  logic [11:0] shown;
  logic        start;
  logic [9:0]  hx, vy;
  logic        in_win;

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [21:0] dabble_step(input logic [21:0] x);
    logic [21:0] t;
    t = x;
    for (int unsigned i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  assign height_sat = (height_in > 10'd999) ? 10'd999 : height_in;

  // The request register doubles as the capture slot and the holding slot;
  // a queued request keeps busy high through the load cycle.
  assign start = req_full && (state != CONVERT);
  assign busy  = (state != IDLE) || req_full;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_full) state_next = CONVERT;
      CONVERT: if (step == 4'd9) state_next = DONE;
      DONE:    state_next = req_full ? CONVERT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_full <= 1'b0;
      req_val  <= '0;
      dd       <= '0;
      step     <= '0;
      pending  <= '0;
      shown    <= '0;
    end else begin
      state <= state_next;
      if (height_valid) begin
        req_val  <= height_sat;
        req_full <= 1'b1;
      end else if (start) begin
        req_full <= 1'b0;
      end
      if (start) begin
        dd   <= {12'h000, req_val};
        step <= '0;
      end else if (state == CONVERT) begin
        dd   <= dabble_step(dd);
        step <= step + 4'd1;
      end
      if (state == DONE) pending <= dd[21:10];
      if (vcount == 10'd480 && hcount == 10'd0) shown <= pending;
    end
  end

  assign hx     = hcount - X0;
  assign vy     = vcount - Y0;
  assign in_win = (hcount >= X0) && (vcount >= Y0) && (hx < 10'd96) && (vy < 10'd32);

  always_comb begin
    glyph_col   = '0;
    glyph_row   = '0;
    glyph_digit = 4'hF;
    if (in_win) begin
      glyph_col = hx[4:0];
      glyph_row = vy[4:0];
      case (hx[6:5])
        2'd0:    glyph_digit = shown[11:8];
        2'd1:    glyph_digit = shown[7:4];
        default: glyph_digit = shown[3:0];
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if (hx[6:5] == 2'd0 && shown[11:8] == 4'd0) glyph_digit = 4'hF;
      if (hx[6:5] == 2'd1 && shown[11:4] == 8'h00) glyph_digit = 4'hF;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             rgb <= '0;
    else if (!video_on)                    rgb <= '0;
    else if (!in_win || glyph_digit == 4'hF) rgb <= BG_COLOR;
    else                                   rgb <= glyph_data;
  end

endmodule

// File: doc/height_digit_render.md
HEIGHT_DIGIT_RENDER -- requirements
Module: height_digit_render

Interface
REQ-001 Parameter X0, default 10'd272, left pixel column of the 3-digit readout window.
REQ-002 Parameter Y0, default 10'd224, top pixel row of the readout window.
REQ-003 Parameter BG_COLOR, default 6'b111111, background colour inside the window and for blanked digits.
REQ-004 clk  in  1  single pixel clock; all state SHALL be clocked on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 height_in  in  10  binary height in cm, sampled when height_valid=1.
REQ-007 height_valid  in  1  single-cycle strobe: new height available.
REQ-008 hcount  in  10  current pixel column from the VGA timing generator.
REQ-009 vcount  in  10  current pixel row from the VGA timing generator.
REQ-010 video_on  in  1  active-video flag aligned with hcount/vcount.
REQ-011 glyph_col  out  5  column address to the digit glyph ROM bank.
REQ-012 glyph_row  out  5  row address to the digit glyph ROM bank.
REQ-013 glyph_digit  out  4  digit select 0-9 to the ROM bank mux; 4'hF = blank.
REQ-014 glyph_data  in  6  combinational ROM bank pixel for the current glyph_digit/row/col.
REQ-015 rgb  out  6  registered pixel colour {R2,G2,B2} to the DAC.
REQ-016 busy  out  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-017 Height >999 SHALL saturate to 999 on capture.
REQ-018 FSM states IDLE, CONVERT, DONE; IDLE->CONVERT on a captured value, CONVERT lasts exactly 10 cycles (one shift-add-3 double-dabble step per cycle), CONVERT->DONE, DONE->IDLE after 1 cycle.
REQ-019 busy SHALL be high in CONVERT and DONE, low in IDLE; busy rises the cycle after the capturing strobe.
REQ-020 In DONE the 12-bit BCD result SHALL be written to a pending register.
REQ-021 height_valid while busy SHALL load a one-entry holding register (latest value wins); on DONE->IDLE a full holding register SHALL start a new conversion immediately without an IDLE dwell cycle, and the register is cleared.
REQ-022 Pending BCD SHALL be copied to the displayed BCD only on the cycle with vcount==480 and hcount==0; strobe and frame-boundary in the same cycle use the previously pending value.
REQ-023 Window: X0<=hcount<X0+96 and Y0<=vcount<Y0+32; digit index = (hcount-X0)>>5 (0 hundreds, 1 tens, 2 units).
REQ-024 Inside the window glyph_col=(hcount-X0)[4:0], glyph_row=(vcount-Y0)[4:0], glyph_digit = selected displayed BCD digit; outside, glyph_col/row=0 and glyph_digit=4'hF.
REQ-025 glyph outputs SHALL be combinational from hcount/vcount/displayed BCD.
REQ-026 rgb latency SHALL be exactly 1 cycle: rgb = 0 if video_on was 0; else BG_COLOR if outside window or glyph_digit was 4'hF; else glyph_data, all sampled the previous cycle.
REQ-027 Window arithmetic SHALL be 10-bit unsigned with no wrap; hcount<X0 or vcount<Y0 is outside.

Reset
REQ-028 Reset SHALL force FSM=IDLE, busy=0, rgb=0, holding register empty, pending and displayed BCD = 12'h000.
REQ-029 Reset asserted mid-conversion SHALL abandon the conversion; no partial result reaches pending BCD.
REQ-030 First rising clk after reset deassertion SHALL accept height_valid normally.

Configuration
REQ-031 Macro LEADING_ZERO_BLANK_EN defined: hundreds digit 0 drives glyph_digit=4'hF; tens digit 0 also blanked when hundreds is 0; units never blanked.
REQ-032 Macro LEADING_ZERO_BLANK_EN undefined: all three digits always displayed, including leading zeros.

Verification
REQ-033 height_in=173 strobe -> busy high 12 cycles; after the next vcount=480/hcount=0, glyph_digit=1 at X0, 7 at X0+32, 3 at X0+64 (row Y0).
REQ-034 height_in=1023 -> displayed digits 9,9,9.
REQ-035 hcount=X0+3, vcount=Y0+1, video_on=1, glyph_data=6'b000000 -> rgb=6'b000000 next cycle; video_on=0 -> rgb=0 next cycle; hcount=X0+96 -> rgb=BG_COLOR.
REQ-036 height_in=5: with LEADING_ZERO_BLANK_EN rgb=BG_COLOR over digits 0-1 and glyph_digit=5 at digit 2; without, glyph_digit 0,0,5.
REQ-037 Strobe 200, then strobes 300 and 412 during CONVERT -> second conversion of 412 starts at DONE->IDLE; displayed 412 after following frame boundary.
REQ-038 reset pulse at CONVERT cycle 5 -> busy=0, rgb=0, displayed 000; subsequent strobe 42 converts and displays correctly.
